mul_ctrl: RTL and testbench
===========================

MUL_CTRL -- requirements
Module: mul_ctrl

Interface
REQ-001 SHALL have parameter BYPASS_ZERO, default 1; when 1, any op with a zero operand completes without launching the multiplier.
REQ-002 SHALL have ports:
- clk  in  1  clock; all state changes on posedge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  pipeline flush; synchronous, highest priority.
- in_valid  in  1  decoded multiply op offered.
- in_ready  out  1  controller can accept an op.
- in_op  in  2  00 mul.w, 01 mulh.w, 10 mulh.wu, 11 reserved.
- in_rd  in  5  destination register tag.
- in_a, in_b  in  32 each  source operands.
- mul_en  out  1  multiplier start.
- mul_is_signed  out  1  multiplier signed mode.
- mul_a, mul_b  out  32 each  multiplier operands.
- mul_stall  out  1  multiplier stall; constant 0.
- mul_flush  out  1  multiplier flush; equals flush.
- mul_out  in  64  multiplier product.
- mul_done  in  1  multiplier result valid (level).
- out_valid  out  1  result offered to writeback.
- out_ready  in  1  writeback accepts the result.
- out_rd  out  5  tag of the result.
- out_data  out  32  selected result word.
- busy  out  1  high whenever state != IDLE.

Function
REQ-003 SHALL implement states IDLE, LAUNCH, WAIT, HOLD; in_ready=1 only in IDLE.
REQ-004 Accept = in_valid & in_ready & ~flush; op, rd, a and b are latched in the accept cycle.
REQ-005 On accept with BYPASS_ZERO=1 and (a==0 | b==0): next state HOLD, out_data=0; out_valid is high in cycle N+1 after accept cycle N.
REQ-006 On any other accept: next state LAUNCH.
REQ-007 LAUNCH lasts exactly one cycle: mul_en=1, mul_a/mul_b = latched operands, mul_is_signed=1 only for op 01; next state WAIT.
REQ-008 mul_en SHALL be 0 in every state except LAUNCH; mul_a/mul_b/mul_is_signed hold their values through WAIT.
REQ-009 In WAIT, the first cycle with mul_done=1 captures the result and moves to HOLD; mul_done outside WAIT is ignored.
REQ-010 Result select: op 00 and 11 -> mul_out[31:0] (op 11 runs with is_signed=0); op 01 and 10 -> mul_out[63:32].
REQ-011 With the 2-cycle multiplier: accept in cycle 0, mul_en in cycle 1, mul_done in cycle 3, out_valid in cycle 4.
REQ-012 HOLD: out_valid=1; out_data and out_rd stay stable until out_valid & out_ready.
REQ-013 Handshake in HOLD -> next state IDLE; no new op is accepted in the same cycle (in_ready=0 in HOLD).
REQ-014 flush in any state -> next state IDLE; out_valid=0 from the next cycle; a handshake in a flush cycle counts as cancelled; mul_flush=flush combinationally.
REQ-015 A stale mul_done arriving after a flush (in IDLE) SHALL NOT produce out_valid.
REQ-016 out_data/out_rd are don't-care when out_valid=0, but SHALL NOT be X after reset.

Reset
REQ-017 rst_n low asynchronously forces: state IDLE, out_valid 0, mul_en 0, busy 0, out_data 0, out_rd 0, latched operands 0.
REQ-018 Reset asserted mid-operation abandons the op; after release the block is in IDLE with in_ready=1 and ignores any pending mul_done.

Verification
REQ-019 mul.w a=7, b=0xFFFFFFFD (-3) -> out_data=0xFFFFFFEB, out_valid 4 cycles after accept.
REQ-020 mulh.w a=b=0x80000000 -> out_data=0x40000000; mulh.wu a=b=0xFFFFFFFF -> out_data=0xFFFFFFFE.
REQ-021 BYPASS_ZERO=1, mul.w a=0, b=0x1234 -> mul_en never asserts, out_valid=1 one cycle after accept, out_data=0.
REQ-022 out_ready held low 5 cycles in HOLD -> out_valid, out_data and out_rd stable; in_ready stays 0; handshake then returns to IDLE.
REQ-023 flush in WAIT, then mul_done pulses next cycle -> no out_valid; the next op's result is correct.
REQ-024 rst_n pulsed low in LAUNCH -> outputs at reset values immediately (asynchronous); the next accepted op completes normally.

Source files
------------

// File: rtl/mul_ctrl.sv
// Multiply-op controller: accepts a decoded RV multiply op, drives an external
// multiplier, selects the result word and holds it for writeback.
`timescale 1ns/1ps
module mul_ctrl #(
    parameter bit BYPASS_ZERO = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_op,
    input  logic [4:0]  in_rd,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic        mul_en,
    output logic        mul_is_signed,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    output logic        mul_stall,
    output logic        mul_flush,
    input  logic [63:0] mul_out,
    input  logic        mul_done,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  out_rd,
    output logic [31:0] out_data,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_HOLD   = 2'd3
    } state_t;

    state_t      state_q;
    logic [1:0]  op_q;
    logic [4:0]  rd_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic        mul_en_q;
    logic        is_signed_q;
    logic        out_valid_q;
    logic [31:0] out_data_q;
    logic        busy_q;

    logic        bypass_hit;
    logic [31:0] result_d;

    assign bypass_hit = BYPASS_ZERO && ((in_a == '0) || (in_b == '0));

    // mulh.w (01) and mulh.wu (10) return the upper word; mul.w and reserved return the lower.
    assign result_d = (op_q[1] ^ op_q[0]) ? mul_out[63:32] : mul_out[31:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            rd_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            mul_en_q    <= 1'b0;
            is_signed_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
        end else if (flush) begin
            state_q     <= S_IDLE;
            mul_en_q    <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        op_q        <= in_op;
                        rd_q        <= in_rd;
                        a_q         <= in_a;
                        b_q         <= in_b;
                        is_signed_q <= (in_op == 2'b01);
                        busy_q      <= 1'b1;
                        if (bypass_hit) begin
                            state_q     <= S_HOLD;
                            out_data_q  <= '0;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q  <= S_LAUNCH;
                            mul_en_q <= 1'b1;
                        end
                    end
                end
                S_LAUNCH: begin
                    mul_en_q <= 1'b0;
                    state_q  <= S_WAIT;
                end
                S_WAIT: begin
                    if (mul_done) begin
                        out_data_q  <= result_d;
                        out_valid_q <= 1'b1;
                        state_q     <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready      = (state_q == S_IDLE);
    assign mul_en        = mul_en_q;
    assign mul_is_signed = is_signed_q;
    assign mul_a         = a_q;
    assign mul_b         = b_q;
    assign mul_stall     = 1'b0;
    assign mul_flush     = flush;
    assign out_valid     = out_valid_q;
    assign out_data      = out_data_q;
    assign out_rd        = rd_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_mul_ctrl.sv
// Directed bench for mul_ctrl with a behavioural 2-cycle multiplier attached.
`timescale 1ns/1ps
module tb_mul_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_op = '0;
    logic [4:0]  in_rd = '0;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic        mul_en;
    logic        mul_is_signed;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic        mul_stall;
    logic        mul_flush;
    logic [63:0] mul_out;
    logic        mul_done;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [4:0]  out_rd;
    logic [31:0] out_data;
    logic        busy;

    int checks = 0;
    int failures = 0;
    int men_cnt = 0;

    mul_ctrl #(.BYPASS_ZERO(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_rd(in_rd),
        .in_a(in_a), .in_b(in_b),
        .mul_en(mul_en), .mul_is_signed(mul_is_signed), .mul_a(mul_a), .mul_b(mul_b),
        .mul_stall(mul_stall), .mul_flush(mul_flush), .mul_out(mul_out), .mul_done(mul_done),
        .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd), .out_data(out_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Two-cycle multiplier: start in cycle k, done pulse in cycle k+2.
    logic        s1 = 1'b0;
    logic        s2 = 1'b0;
    logic        inj_done = 1'b0;
    logic [63:0] prod = '0;
    always @(posedge clk) begin
        s1 <= mul_en;
        s2 <= s1;
        if (mul_en) begin
            if (mul_is_signed)
                prod <= $signed({{32{mul_a[31]}}, mul_a}) * $signed({{32{mul_b[31]}}, mul_b});
            else
                prod <= {32'b0, mul_a} * {32'b0, mul_b};
        end
        if (mul_en) men_cnt++;
    end
    assign mul_done = s2 | inj_done;
    assign mul_out  = prod;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept_op(input logic [1:0] op, input logic [4:0] rd,
                             input logic [31:0] a, input logic [31:0] b);
        in_valid = 1'b1; in_op = op; in_rd = rd; in_a = a; in_b = b;
        tick();
        in_valid = 1'b0; in_op = 2'b11; in_rd = 5'h1f; in_a = 32'hDEADBEEF; in_b = 32'hCAFEF00D;
    endtask

    task automatic wait_out(input int start, output int n);
        n = start;
        while (out_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (out_valid !== 1'b1) n = -1;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (mul_en !== 1'b0) begin failures++; $display("FAIL reset_mul_en got=%b exp=0", mul_en); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (out_data !== 32'h0) begin failures++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
        checks++; if (out_rd !== 5'h0) begin failures++; $display("FAIL reset_out_rd got=%h exp=0", out_rd); end
        checks++; if (mul_a !== 32'h0 || mul_b !== 32'h0) begin failures++; $display("FAIL reset_operands got=%h/%h exp=0/0", mul_a, mul_b); end
        checks++; if (mul_stall !== 1'b0) begin failures++; $display("FAIL reset_mul_stall got=%b exp=0", mul_stall); end
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        $display("reset released at %0t", $time);
    endtask

    task automatic test_mulw();
        int n;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL mulw_idle_ready got=%b exp=1", in_ready); end
        accept_op(2'b00, 5'd3, 32'd7, 32'hFFFFFFFD);
        checks++; if (mul_en !== 1'b1) begin failures++; $display("FAIL mulw_launch_en got=%b exp=1", mul_en); end
        checks++; if (mul_a !== 32'd7 || mul_b !== 32'hFFFFFFFD) begin failures++; $display("FAIL mulw_launch_ops got=%h/%h exp=00000007/fffffffd", mul_a, mul_b); end
        checks++; if (mul_is_signed !== 1'b0) begin failures++; $display("FAIL mulw_signed got=%b exp=0", mul_is_signed); end
        checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin failures++; $display("FAIL mulw_busy got=%b/%b exp=1/0", busy, in_ready); end
        tick();
        checks++; if (mul_en !== 1'b0) begin failures++; $display("FAIL mulw_wait_en got=%b exp=0", mul_en); end
        checks++; if (mul_a !== 32'd7 || mul_b !== 32'hFFFFFFFD) begin failures++; $display("FAIL mulw_wait_ops got=%h/%h exp=00000007/fffffffd", mul_a, mul_b); end
        wait_out(2, n);
        checks++; if (n !== 4) begin failures++; $display("FAIL mulw_latency got=%0d exp=4", n); end
        checks++; if (out_data !== 32'hFFFFFFEB) begin failures++; $display("FAIL mulw_data got=%h exp=ffffffeb", out_data); end
        checks++; if (out_rd !== 5'd3) begin failures++; $display("FAIL mulw_rd got=%0d exp=3", out_rd); end
        $display("mul.w    rd=%0d data=%h latency=%0d", out_rd, out_data, n);
        handshake();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL mulw_done got v=%b r=%b b=%b exp=0/1/0", out_valid, in_ready, busy); end
    endtask

    task automatic test_mulh();
        int n;
        accept_op(2'b01, 5'd4, 32'h80000000, 32'h80000000);
        checks++; if (mul_is_signed !== 1'b1) begin failures++; $display("FAIL mulh_signed got=%b exp=1", mul_is_signed); end
        wait_out(1, n);
        checks++; if (n !== 4 || out_data !== 32'h40000000) begin failures++; $display("FAIL mulh_data got=%h lat=%0d exp=40000000 lat=4", out_data, n); end
        $display("mulh.w   rd=%0d data=%h latency=%0d", out_rd, out_data, n);
        handshake();
        accept_op(2'b10, 5'd5, 32'hFFFFFFFF, 32'hFFFFFFFF);
        checks++; if (mul_is_signed !== 1'b0) begin failures++; $display("FAIL mulhu_signed got=%b exp=0", mul_is_signed); end
        wait_out(1, n);
        checks++; if (n !== 4 || out_data !== 32'hFFFFFFFE || out_rd !== 5'd5) begin failures++; $display("FAIL mulhu_data got=%h rd=%0d lat=%0d exp=fffffffe rd=5 lat=4", out_data, out_rd, n); end
        $display("mulh.wu  rd=%0d data=%h latency=%0d", out_rd, out_data, n);
        handshake();
    endtask

    task automatic test_reserved();
        int n;
        accept_op(2'b11, 5'd6, 32'd3, 32'd5);
        checks++; if (mul_is_signed !== 1'b0) begin failures++; $display("FAIL rsvd_signed got=%b exp=0", mul_is_signed); end
        wait_out(1, n);
        checks++; if (n !== 4 || out_data !== 32'd15) begin failures++; $display("FAIL rsvd_data got=%h lat=%0d exp=0000000f lat=4", out_data, n); end
        $display("op11     rd=%0d data=%h latency=%0d", out_rd, out_data, n);
        handshake();
    endtask

    task automatic test_bypass();
        int n;
        men_cnt = 0;
        accept_op(2'b00, 5'd7, 32'h0, 32'h1234);
        wait_out(1, n);
        checks++; if (n !== 1) begin failures++; $display("FAIL bypass_latency got=%0d exp=1", n); end
        checks++; if (out_data !== 32'h0 || out_rd !== 5'd7) begin failures++; $display("FAIL bypass_data got=%h rd=%0d exp=0 rd=7", out_data, out_rd); end
        $display("bypass   rd=%0d data=%h latency=%0d", out_rd, out_data, n);
        handshake();
        accept_op(2'b01, 5'd8, 32'd5, 32'h0);
        wait_out(1, n);
        checks++; if (n !== 1 || out_data !== 32'h0) begin failures++; $display("FAIL bypass_b0 got=%h lat=%0d exp=0 lat=1", out_data, n); end
        $display("bypass   rd=%0d data=%h latency=%0d", out_rd, out_data, n);
        handshake();
        checks++; if (men_cnt !== 0) begin failures++; $display("FAIL bypass_mul_en got=%0d pulses exp=0", men_cnt); end
    endtask

    task automatic test_hold_stall();
        int n;
        accept_op(2'b10, 5'd9, 32'h80000000, 32'd2);
        wait_out(1, n);
        checks++; if (n !== 4 || out_data !== 32'h1) begin failures++; $display("FAIL stall_data got=%h lat=%0d exp=00000001 lat=4", out_data, n); end
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_a = 32'd11; in_b = 32'd13;
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_data !== 32'h1 || out_rd !== 5'd9 || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL stall_hold cyc=%0d got v=%b d=%h rd=%0d r=%b exp 1/00000001/9/0", i, out_valid, out_data, out_rd, in_ready);
            end
        end
        in_valid = 1'b0;
        $display("stalled  rd=%0d data=%h held 5 cycles", out_rd, out_data);
        handshake();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL stall_release got v=%b r=%b exp=0/1", out_valid, in_ready); end
    endtask

    task automatic test_flush();
        int n;
        accept_op(2'b00, 5'd10, 32'd6, 32'd7);
        tick();
        checks++; if (mul_flush !== 1'b0) begin failures++; $display("FAIL flush_idle_level got=%b exp=0", mul_flush); end
        flush = 1'b1;
        #1;
        checks++; if (mul_flush !== 1'b1) begin failures++; $display("FAIL flush_passthru got=%b exp=1", mul_flush); end
        @(posedge clk); #1;
        flush = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL flush_wait got v=%b r=%b b=%b exp=0/1/0", out_valid, in_ready, busy); end
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_stale_done got=%b exp=0", out_valid); end
        $display("flush    in WAIT, stale done dropped");
        accept_op(2'b00, 5'd11, 32'd9, 32'd9);
        wait_out(1, n);
        checks++; if (n !== 4 || out_data !== 32'h51 || out_rd !== 5'd11) begin failures++; $display("FAIL flush_next got=%h rd=%0d lat=%0d exp=00000051 rd=11 lat=4", out_data, out_rd, n); end
        $display("mul.w    rd=%0d data=%h latency=%0d", out_rd, out_data, n);
        out_ready = 1'b1; flush = 1'b1;
        tick();
        out_ready = 1'b0; flush = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL flush_hold got v=%b r=%b exp=0/1", out_valid, in_ready); end
        in_valid = 1'b1; in_a = 32'd1; in_b = 32'd1; flush = 1'b1;
        tick();
        in_valid = 1'b0; flush = 1'b0;
        checks++; if (busy !== 1'b0 || in_ready !== 1'b1 || mul_en !== 1'b0) begin failures++; $display("FAIL flush_accept got b=%b r=%b en=%b exp=0/1/0", busy, in_ready, mul_en); end
        $display("flush    in HOLD and on offered op");
    endtask

    task automatic test_reset_mid();
        int n;
        accept_op(2'b00, 5'd12, 32'h10, 32'h20);
        checks++; if (mul_en !== 1'b1) begin failures++; $display("FAIL rstmid_launch got=%b exp=1", mul_en); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (mul_en !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_async got en=%b b=%b r=%b v=%b exp=0/0/1/0", mul_en, busy, in_ready, out_valid); end
        checks++; if (mul_a !== 32'h0 || out_rd !== 5'h0 || out_data !== 32'h0) begin failures++; $display("FAIL rstmid_regs got a=%h rd=%0d d=%h exp=0/0/0", mul_a, out_rd, out_data); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        inj_done = 1'b1;
        tick();
        inj_done = 1'b0;
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rstmid_stale got v=%b b=%b exp=0/0", out_valid, busy); end
        $display("reset    mid-LAUNCH, op abandoned");
        accept_op(2'b00, 5'd13, 32'h10, 32'h20);
        wait_out(1, n);
        checks++; if (n !== 4 || out_data !== 32'h200 || out_rd !== 5'd13) begin failures++; $display("FAIL rstmid_next got=%h rd=%0d lat=%0d exp=00000200 rd=13 lat=4", out_data, out_rd, n); end
        $display("mul.w    rd=%0d data=%h latency=%0d", out_rd, out_data, n);
        handshake();
    endtask

    initial begin
        test_reset();
        test_mulw();
        test_mulh();
        test_reserved();
        test_bypass();
        test_hold_stall();
        test_flush();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
